// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flush sequencing, data-memory
// freeze with a timeout watchdog, and saturating performance counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      Instruc_IFID,
    input  logic [4:0]       rd_IDEX,
    input  logic             memRead_IDEX,
    input  logic             flush_IF,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             clear_err,
    input  logic             perf_clr,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             control_mux_sel,
    output logic             flush_IFID,
    output logic             stall_pipe,
    output logic             mem_err,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MEM_ERR  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WC_W-1:0] wcnt_q, wcnt_d;
    logic            mem_err_q;
    logic [CNT_W-1:0] bubble_cnt_q, flush_cnt_q, stall_cnt_q;

    logic [6:0] opcode;
    logic [4:0] rs1, rs2;
    logic       use_rs1, use_rs2;
    logic       lu_hz, mem_stall;
    logic       unused_instr;

    assign opcode = Instruc_IFID[6:0];
    assign rs1    = Instruc_IFID[19:15];
    assign rs2    = Instruc_IFID[24:20];
    assign unused_instr = ^{Instruc_IFID[31:25], Instruc_IFID[14:7]};

    assign use_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    assign use_rs2 = (opcode == OP_R || opcode == OP_S || opcode == OP_B);

    assign lu_hz = memRead_IDEX && (rd_IDEX != 5'd0) &&
                   ((use_rs1 && rd_IDEX == rs1) || (use_rs2 && rd_IDEX == rs2));

    // A latched error keeps the whole pipeline frozen until software clears it.
    assign mem_stall = (state_q == ST_MEM_ERR) || (dmem_req && !dmem_ready);

    assign stall_pipe      = mem_stall;
    assign PCWrite         = !(mem_stall || lu_hz);
    assign IFIDWrite       = !(mem_stall || lu_hz);
    assign control_mux_sel = lu_hz && !mem_stall;
    assign flush_IFID      = flush_IF && !lu_hz && !mem_stall;

    assign mem_err    = mem_err_q;
    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign stall_cnt  = stall_cnt_q;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_RUN: begin
                if (dmem_req && !dmem_ready) begin
                    state_d = ST_MEM_WAIT;
                    wcnt_d  = WC_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                // Ready arriving in the final tolerated cycle still wins over the timeout.
                if (dmem_ready) begin
                    state_d = ST_RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q == WC_W'(MEM_TIMEOUT)) begin
                    state_d = ST_MEM_ERR;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ST_MEM_ERR: begin
                if (clear_err) begin
                    state_d = ST_RUN;
                    wcnt_d  = '0;
                end
            end
            default: begin
                state_d = ST_RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic clr);
        if (clr)
            return '0;
        else if (inc && !(&cnt))
            return cnt + 1'b1;
        else
            return cnt;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            wcnt_q       <= '0;
            mem_err_q    <= 1'b0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            mem_err_q    <= (state_d == ST_MEM_ERR);
            bubble_cnt_q <= cnt_next(bubble_cnt_q, control_mux_sel, perf_clr);
            flush_cnt_q  <= cnt_next(flush_cnt_q, flush_IFID, perf_clr);
            stall_cnt_q  <= cnt_next(stall_cnt_q, stall_pipe, perf_clr);
        end
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. Decodes the IF/ID instruction against the ID/EX load destination to insert load-use bubbles. Sequences branch flushes and freezes the whole pipeline while data memory is not ready, with a timeout watchdog. Drives the PC/IF-ID write enables, the ID-stage `control_mux_sel` bubble select and the IF/ID flush, and keeps saturating performance counters.

## Interface
Parameters:
- `MEM_TIMEOUT`, 16: maximum consecutive not-ready cycles tolerated in MEM_WAIT before error (≥2).
- `CNT_W`, 16: width of each performance counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Instruc_IFID`  in  32  instruction in IF/ID.
- `rd_IDEX`  in  5  destination of instruction in ID/EX.
- `memRead_IDEX`  in  1  ID/EX instruction is a load.
- `flush_IF`  in  1  taken-branch request from the ID flush unit.
- `dmem_req`  in  1  MEM stage is accessing data memory.
- `dmem_ready`  in  1  data memory completes this cycle.
- `clear_err`  in  1  one-cycle pulse, leaves MEM_ERR.
- `perf_clr`  in  1  synchronous clear of all counters.
- `PCWrite`  out  1  PC update enable.
- `IFIDWrite`  out  1  IF/ID register enable.
- `control_mux_sel`  out  1  zero ID control signals (bubble).
- `flush_IFID`  out  1  replace IF/ID with NOP.
- `stall_pipe`  out  1  freeze ID/EX, EX/MEM, MEM/WB.
- `mem_err`  out  1  sticky timeout flag.
- `bubble_cnt`  out  CNT_W  load-use bubbles inserted.
- `flush_cnt`  out  CNT_W  branch flushes issued.
- `stall_cnt`  out  CNT_W  memory-freeze cycles.

## Operation
- Operand decode from `Instruc_IFID`: rs1 = [19:15], rs2 = [24:20], opcode = [6:0].
  - `use_rs1` = opcode not in {0110111 LUI, 0010111 AUIPC, 1101111 JAL}.
  - `use_rs2` = opcode in {0110011 R, 0100011 S, 1100011 B}.
- `lu_hz` = `memRead_IDEX` && `rd_IDEX`≠0 && ((`use_rs1` && `rd_IDEX`==rs1) || (`use_rs2` && `rd_IDEX`==rs2)).
- `mem_stall` = (state==MEM_ERR) || (`dmem_req` && !`dmem_ready`).
- Outputs are combinational, with priority mem_stall > lu_hz > flush_IF:
  - `stall_pipe` = `mem_stall`.
  - `PCWrite` = `IFIDWrite` = !(`mem_stall` || `lu_hz`).
  - `control_mux_sel` = `lu_hz` && !`mem_stall`.
  - `flush_IFID` = `flush_IF` && !`lu_hz` && !`mem_stall`. A branch that depends on a load is re-evaluated after the bubble.
- FSM, with a wait counter `wcnt` (width ⌈log2(MEM_TIMEOUT+1)⌉):
  - RUN: if `dmem_req` && !`dmem_ready` → MEM_WAIT, `wcnt`←1.
  - MEM_WAIT:
    - If `dmem_ready` → RUN, `wcnt`←0.
    - Else if `wcnt`==MEM_TIMEOUT → MEM_ERR, `mem_err`←1.
    - Else `wcnt`++.
  - MEM_ERR: pipeline held frozen regardless of `dmem_ready`. `clear_err` → RUN, `mem_err`←0, `wcnt`←0.
  - `clear_err` is ignored outside MEM_ERR.
- Counters saturate at 2^CNT_W−1 and never wrap.
  - `bubble_cnt` increments on each cycle with `control_mux_sel`.
  - `flush_cnt` increments on each cycle with `flush_IFID`.
  - `stall_cnt` increments on each cycle with `stall_pipe`.
  - `perf_clr` zeroes all three and takes priority over an increment in the same cycle.

## Timing
- Reset (async assert): state RUN, `wcnt`=0, `mem_err`=0, all counters 0.
  - With inputs idle, outputs after reset are `PCWrite`=`IFIDWrite`=1 and all others 0.
- Hazard outputs have zero latency: they are valid in the same cycle as their inputs.
- A load-use hazard yields exactly one bubble. Next cycle ID/EX holds the bubble (`memRead_IDEX`=0), so `lu_hz` clears.
- Counters and `mem_err` update on the rising edge following the qualifying cycle.
- Timeout: with `dmem_ready` held low from cycle 0, `stall_pipe` is high in cycles 0..MEM_TIMEOUT and then stays high. `mem_err` rises at the edge ending cycle MEM_TIMEOUT.
- `dmem_ready` rising in cycle MEM_TIMEOUT wins: the FSM returns to RUN and no error is raised.
- Reset asserted mid-MEM_WAIT or in MEM_ERR returns immediately to RUN and clears `mem_err`.

## Test plan
- Load-use: `memRead_IDEX`=1, `rd_IDEX`=5, IF/ID `add x7,x5,x6` → one cycle with `PCWrite`=0, `IFIDWrite`=0, `control_mux_sel`=1; `bubble_cnt` goes to 1.
- No false hazard: `rd_IDEX`=0, or `lui x5` in IF/ID with `rd_IDEX`=5 → no stall. `addi x7,x6,1` with `rd_IDEX`=6 → stall (rs2 field ignored for I-type).
- Priority: `flush_IF`=1 with a concurrent load-use hazard → `flush_IFID`=0 and bubble inserted. Next cycle `flush_IF`=1 → `flush_IFID`=1; `flush_cnt` goes to 1.
- Memory wait: `dmem_req`=1, `dmem_ready` low for 3 cycles then high → `stall_pipe` high for exactly 3 cycles, `PCWrite` low for those cycles; `stall_cnt` reaches 3; FSM back in RUN.
- Timeout: MEM_TIMEOUT=4, `dmem_ready` held low → `mem_err`=1 after the 5th stalled cycle, and the freeze persists after `dmem_ready`=1. `clear_err` pulse → `mem_err`=0 and `stall_pipe`=0 the next cycle.
- Saturation/reset: CNT_W=2, 5 bubbles → `bubble_cnt`=3. `perf_clr` together with a bubble → 0. `rst_n` low in MEM_ERR → all outputs at reset values.
